// File: rtl/alu_operand_sequencer.sv
// Purpose: serial operand loader and result holder for the Pre_Alu combinational stage.
// Latency: result captured one edge after the B beat; at most one operation is in flight (4 cycles minimum).
// Backpressure: In_Ready is low from B capture until the result handshake; Res/Res_Valid hold while Res_Ready is low.
// Optional feature: define ALU_SEQ_COUNT_EN to add the 8-bit Op_Count completed-operation counter port.
module alu_operand_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Sel,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Sel,
    input  logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] Res,
    output logic             Res_Valid,
    input  logic             Res_Ready
`ifdef ALU_SEQ_COUNT_EN
    ,
    output logic [7:0]       Op_Count
`endif
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Beats are accepted only while loading operands.
    logic in_fire;
    assign in_fire = In_Valid & In_Ready;

    // State register; reset returns to LOAD_A from anywhere.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: two load beats, one execute cycle, then wait for the result handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD_A:  if (in_fire)   state_nxt = LOAD_B;
            LOAD_B:  if (in_fire)   state_nxt = EXEC;
            EXEC:                   state_nxt = HOLD;
            HOLD:    if (Res_Ready) state_nxt = LOAD_A;
            default:                state_nxt = LOAD_A;
        endcase
    end

    // In_Ready is decoded from the state register alone so there is no path from In_Valid.
    always_comb begin
        In_Ready = 1'b0;
        case (state)
            LOAD_A:  In_Ready = 1'b1;
            LOAD_B:  In_Ready = 1'b1;
            default: In_Ready = 1'b0;
        endcase
    end

    // Operand and result registers; each changes only at its own capture edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            A         <= '0;
            B         <= '0;
            Sel       <= 1'b0;
            Res       <= '0;
            Res_Valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (In_Valid) A <= In_Data;
                end
                LOAD_B: begin
                    if (In_Valid) begin
                        B   <= In_Data;
                        Sel <= In_Sel;
                    end
                end
                EXEC: begin
                    Res       <= C;
                    Res_Valid <= 1'b1;
                end
                HOLD: begin
                    if (Res_Ready) Res_Valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_COUNT_EN
    // Completed-operation counter, stepped on the result handshake; wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Op_Count <= 8'd0;
        end else if ((state == HOLD) && Res_Ready) begin
            Op_Count <= Op_Count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Purpose: directed self-checking bench for alu_operand_sequencer.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: exercises Res_Ready held low and In_Valid gaps.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] In_Data;
    logic       In_Sel;
    logic       In_Valid;
    logic       In_Ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       Sel;
    logic [3:0] C;
    logic [3:0] Res;
    logic       Res_Valid;
    logic       Res_Ready;
`ifdef ALU_SEQ_COUNT_EN
    logic [7:0] Op_Count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .In_Data   (In_Data),
        .In_Sel    (In_Sel),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .A         (A),
        .B         (B),
        .Sel       (Sel),
        .C         (C),
        .Res       (Res),
        .Res_Valid (Res_Valid),
        .Res_Ready (Res_Ready)
`ifdef ALU_SEQ_COUNT_EN
        ,
        .Op_Count  (Op_Count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the sequencer takes it (bounded wait).
    task automatic send_beat(input logic [3:0] d, input logic s);
        int n;
        n = 0;
        In_Data  = d;
        In_Sel   = s;
        In_Valid = 1'b1;
        while (!In_Ready && n < 20) begin
            step();
            n++;
        end
        if (n == 20) chk("beat_timeout", {31'd0, In_Ready}, 32'd1);
        step();
        In_Valid = 1'b0;
    endtask

    // Full operation with Res_Ready high; returns once the handshake edge has passed.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [3:0] c);
        int n;
        Res_Ready = 1'b1;
        send_beat(a, 1'b0);
        send_beat(b, s);
        C = c;
        n = 0;
        while (!Res_Valid && n < 20) begin
            step();
            n++;
        end
        if (n == 20) chk("res_timeout", {31'd0, Res_Valid}, 32'd1);
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        In_Data   = 4'd0;
        In_Sel    = 1'b0;
        In_Valid  = 1'b0;
        C         = 4'd0;
        Res_Ready = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);
        chk("rst_a", A, 32'd0);
        chk("rst_b", B, 32'd0);
        chk("rst_sel", {31'd0, Sel}, 32'd0);
        chk("rst_res", Res, 32'd0);
        chk("rst_res_valid", {31'd0, Res_Valid}, 32'd0);
`ifdef ALU_SEQ_COUNT_EN
        chk("rst_op_count", Op_Count, 32'd0);
`endif
        rst_n = 1'b1;

        // Single operation: 5, 10, Sel 0, C = F
        Res_Ready = 1'b1;
        send_beat(4'd5, 1'b0);
        chk("op1_a_after_a_beat", A, 32'd5);
        send_beat(4'd10, 1'b0);
        // Now in EXEC: operands stable, no result yet, not ready
        chk("op1_a", A, 32'd5);
        chk("op1_b", B, 32'd10);
        chk("op1_sel", {31'd0, Sel}, 32'd0);
        chk("op1_exec_in_ready", {31'd0, In_Ready}, 32'd0);
        chk("op1_exec_res_valid", {31'd0, Res_Valid}, 32'd0);
        C = 4'hF;
        step();
        chk("op1_res_valid", {31'd0, Res_Valid}, 32'd1);
        chk("op1_res", Res, 32'hF);
        step();
        chk("op1_done_res_valid", {31'd0, Res_Valid}, 32'd0);
        chk("op1_done_in_ready", {31'd0, In_Ready}, 32'd1);

        // Backpressure: 8, 4, Sel 1, C = 4, Res_Ready low for 5 cycles
        Res_Ready = 1'b0;
        send_beat(4'd8, 1'b0);
        send_beat(4'd4, 1'b1);
        chk("bp_sel", {31'd0, Sel}, 32'd1);
        C = 4'h4;
        step();
        chk("bp_res_valid_rise", {31'd0, Res_Valid}, 32'd1);
        C = 4'hA;               // C changes after capture; Res must not follow
        In_Data  = 4'd6;
        In_Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_res", Res, 32'd4);
            chk("bp_res_valid", {31'd0, Res_Valid}, 32'd1);
            chk("bp_in_ready", {31'd0, In_Ready}, 32'd0);
            chk("bp_a_kept", A, 32'd8);
        end
        In_Valid  = 1'b0;
        Res_Ready = 1'b1;
        step();
        chk("bp_release_res_valid", {31'd0, Res_Valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, In_Ready}, 32'd1);
        chk("bp_extra_not_consumed", A, 32'd8);

        // In_Valid gaps between A and B beats
        send_beat(4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap_in_ready", {31'd0, In_Ready}, 32'd1);
            chk("gap_a", A, 32'd3);
            chk("gap_b_unchanged", B, 32'd4);
        end
        send_beat(4'd2, 1'b0);
        chk("gap_b", B, 32'd2);
        chk("gap_sel", {31'd0, Sel}, 32'd0);
        C = 4'h9;
        step();
        chk("gap_res_valid", {31'd0, Res_Valid}, 32'd1);
        chk("gap_res", Res, 32'h9);
        step();
        chk("gap_done_in_ready", {31'd0, In_Ready}, 32'd1);

        // Reset after the A beat discards A
        send_beat(4'd6, 1'b0);
        chk("mid_a_loaded", A, 32'd6);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_a", A, 32'd0);
        chk("mid_rst_in_ready", {31'd0, In_Ready}, 32'd1);

        // Reset while a result is pending drops it
        Res_Ready = 1'b0;
        send_beat(4'd1, 1'b0);
        send_beat(4'd1, 1'b1);
        C = 4'h2;
        step();
        chk("hold_rst_pre_valid", {31'd0, Res_Valid}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("hold_rst_res_valid", {31'd0, Res_Valid}, 32'd0);
        chk("hold_rst_in_ready", {31'd0, In_Ready}, 32'd1);

        // Fresh operation after reset: 6, 3, Sel 1
        run_op(4'd6, 4'd3, 1'b1, 4'h7);
        chk("fresh_a", A, 32'd6);
        chk("fresh_b", B, 32'd3);
        chk("fresh_sel", {31'd0, Sel}, 32'd1);
        chk("fresh_res", Res, 32'h7);
        chk("fresh_res_valid", {31'd0, Res_Valid}, 32'd0);

`ifdef ALU_SEQ_COUNT_EN
        // Counter wrap: 255 ops then one more
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("cnt_reset", Op_Count, 32'd0);
        for (int i = 0; i < 255; i++) begin
            run_op(4'(i), 4'(i + 1), 1'b0, 4'(i + 2));
        end
        chk("cnt_255", Op_Count, 32'd255);
        run_op(4'd1, 4'd2, 1'b1, 4'd3);
        chk("cnt_wrap", Op_Count, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
